// File: rtl/spi_slave_out.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_out
//  Description : SPI mode-0 slave transmitter, MSB first, oversampled on clk.
//                Shifts a parallel word out on miso while an external master
//                clocks sck under cs. All pin inputs are synchronised inside.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_out #(
    parameter int WIDTH = 32,
    parameter int SYNC  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sck,
    input  logic [WIDTH-1:0] in_buf,
    output logic             miso,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_width = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Synchroniser chains, edge-history flops and arming logic
    logic [SYNC-1:0] r_cs_sync;
    logic [SYNC-1:0] r_sck_sync;
    logic [SYNC-1:0] r_fill;
    logic            r_cs_hist;
    logic            r_sck_hist;
    logic            r_armed;

    logic w_cs_s;
    logic w_sck_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs_s     = r_cs_sync[SYNC-1];
    assign w_sck_s    = r_sck_sync[SYNC-1];
    assign w_cs_fall  = r_cs_hist & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_hist & w_cs_s;
    assign w_sck_rise = ~r_sck_hist & w_sck_s;
    assign w_sck_fall = r_sck_hist & ~w_sck_s;

    // Bring cs/sck into the clk domain; r_fill marks when the chain holds
    // only genuine pin samples, so a cs already low at reset release can
    // never masquerade as a falling edge before cs has been seen high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync  <= '1;
            r_sck_sync <= '0;
            r_cs_hist  <= 1'b1;
            r_sck_hist <= 1'b0;
            r_fill     <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC-2:0], cs};
            r_sck_sync <= {r_sck_sync[SYNC-2:0], sck};
            r_cs_hist  <= w_cs_s;
            r_sck_hist <= w_sck_s;
            r_fill     <= {r_fill[SYNC-2:0], 1'b1};
            if (r_fill[SYNC-1] && w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Transaction state
    state_t             r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_shift;

    state_t             w_state_nx;
    logic [c_cnt_w-1:0] w_count_nx;
    logic [WIDTH-1:0]   w_shift_nx;
    logic               w_miso_nx;
    logic               w_busy_nx;
    logic               w_done_nx;

    // The top bit of the shift register is presented on miso at load time
    // and is never read back from the register itself.
    logic w_unused;
    assign w_unused = r_shift[WIDTH-1];

    // State, counter, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_shift <= '0;
            miso    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_shift <= w_shift_nx;
            miso    <= w_miso_nx;
            busy    <= w_busy_nx;
            done    <= w_done_nx;
        end
    end

    // Next-state and output decode; cs_rise takes priority over sck edges
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_shift_nx = r_shift;
        w_miso_nx  = miso;
        w_busy_nx  = busy;
        w_done_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_miso_nx = 1'b0;
                w_busy_nx = 1'b0;
                if (r_armed && w_cs_fall) begin
                    w_shift_nx = in_buf;
                    w_miso_nx  = in_buf[WIDTH-1];
                    w_count_nx = '0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (w_cs_rise) begin
                    // A rise landing with the final sck_rise still completes
                    w_done_nx  = w_sck_rise && (r_count == c_last);
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_miso_nx  = 1'b0;
                end else if (w_sck_rise) begin
                    // Master samples here, so miso is left untouched
                    w_count_nx = r_count + c_one;
                    if (r_count == c_last) begin
                        w_state_nx = S_FULL;
                    end
                end else if (w_sck_fall && (r_count < c_width)) begin
                    w_shift_nx = {r_shift[WIDTH-2:0], 1'b0};
                    w_miso_nx  = r_shift[WIDTH-2];
                end
            end

            S_FULL: begin
                if (w_cs_rise) begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_miso_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end else if (w_sck_fall) begin
                    w_miso_nx = 1'b0;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
                w_miso_nx  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_out
//  Description : Self-checking bench for spi_slave_out. An SPI master model
//                drives cs/sck, reassembles miso and compares against a
//                bit-stream model of the transmitted word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_out;

    localparam int WIDTH = 32;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;   // sck half period in clk cycles (80 ns)

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        cs     = 1'b1;
    logic        sck    = 1'b0;
    logic [31:0] in_buf = '0;
    logic        miso;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    spi_slave_out #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .sck    (sck),
        .in_buf (in_buf),
        .miso   (miso),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n clocks, then settle 3 ns past the edge before driving
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Bit stream a master reads: word MSB first, then zeros after WIDTH
    function automatic logic [63:0] model_stream(input logic [31:0] word, input int nbits);
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < nbits; i++) begin
            e = {e[62:0], (i < WIDTH) ? word[WIDTH-1-i] : 1'b0};
        end
        return e;
    endfunction

    // Watch done for a fixed window after cs rises
    task automatic watch_done(input int ncyc, output int cnt, output int pos);
        cnt = 0;
        pos = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cnt++;
                pos = k;
            end
        end
        #2;
    endtask

    // Full master transaction of nbits sck cycles
    task automatic run_xfer(input logic [31:0] word, input int nbits,
                            input int change_after, input logic [31:0] new_word,
                            output logic [63:0] got, output bit busy_ok,
                            output int done_cnt, output int done_pos);
        got     = '0;
        busy_ok = 1'b1;
        in_buf  = word;
        cs      = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            got = {got[62:0], miso};
            if (busy !== 1'b1) busy_ok = 1'b0;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
            if (i == change_after) in_buf = new_word;
            tick(HALF);
        end
        cs = 1'b1;
        watch_done(12, done_cnt, done_pos);
        tick(4);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_async_miso: got %b want 0", miso); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_async_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_async_done: got %b want 0", done); end
        tick(3);
        reset = 1'b0;
        tick(6);
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_idle_miso: got %b want 0", miso); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_idle_done: got %b want 0", done); end
    endtask

    task automatic test_full();
        logic [63:0] got;
        bit          bok;
        int          dc, dp;
        run_xfer(32'h4A230010, 32, -1, '0, got, bok, dc, dp);
        n_checks++; if (got[31:0] !== model_stream(32'h4A230010, 32)) begin n_fail++; $display("FAIL full_data: got %h want %h", got[31:0], 32'h4A230010); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL full_busy: busy dropped during transfer"); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", dc); end
        n_checks++; if (dp != SYNC + 1) begin n_fail++; $display("FAIL full_done_latency: got %0d want %0d", dp, SYNC + 1); end
        n_checks++; if (busy !== 1'b0 || miso !== 1'b0) begin n_fail++; $display("FAIL full_after: busy %b miso %b want 0 0", busy, miso); end
    endtask

    task automatic test_stable_data();
        logic [63:0] got;
        bit          bok;
        int          dc, dp;
        run_xfer(32'h4A230010, 32, 3, 32'hFFFFFFFF, got, bok, dc, dp);
        n_checks++; if (got[31:0] !== model_stream(32'h4A230010, 32)) begin n_fail++; $display("FAIL stable_data: got %h want %h", got[31:0], 32'h4A230010); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL stable_done: got %0d want 1", dc); end
    endtask

    task automatic test_abort();
        logic [63:0] got;
        bit          bok;
        int          dc, dp;
        in_buf = 32'hFFFFFFFF;
        cs     = 1'b0;
        tick(HALF);
        for (int i = 0; i < 10; i++) begin
            sck = 1'b1; tick(HALF);
            sck = 1'b0; tick(HALF);
        end
        cs = 1'b1;
        watch_done(12, dc, dp);
        n_checks++; if (dc != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", dc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso: got %b want 0", miso); end
        tick(4);
        run_xfer(32'h12345678, 32, -1, '0, got, bok, dc, dp);
        n_checks++; if (got[31:0] !== model_stream(32'h12345678, 32)) begin n_fail++; $display("FAIL abort_next_data: got %h want %h", got[31:0], 32'h12345678); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL abort_next_done: got %0d want 1", dc); end
    endtask

    task automatic test_overrun();
        logic [63:0] got;
        logic [63:0] exp;
        bit          bok;
        int          dc, dp;
        exp = model_stream(32'h80000001, 36);
        run_xfer(32'h80000001, 36, -1, '0, got, bok, dc, dp);
        n_checks++; if (got[35:0] !== exp[35:0]) begin n_fail++; $display("FAIL overrun_data: got %h want %h", got[35:0], exp[35:0]); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL overrun_done: got %0d want 1", dc); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        bit          bok;
        bit          quiet;
        int          dc, dp;
        in_buf = 32'hFFFFFFFF;
        cs     = 1'b0;
        tick(HALF);
        for (int i = 0; i < 16; i++) begin
            sck = 1'b1; tick(HALF);
            sck = 1'b0; tick(HALF);
        end
        n_checks++; if (miso !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: miso %b busy %b want 1 1", miso, busy); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL midreset_miso: got %b want 0", miso); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", done); end
        tick(3);
        reset = 1'b0;
        quiet = 1'b1;
        tick(HALF);
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b0 || miso !== 1'b0) quiet = 1'b0;
            sck = 1'b1; tick(HALF);
            if (busy !== 1'b0 || miso !== 1'b0) quiet = 1'b0;
            sck = 1'b0; tick(HALF);
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL midreset_quiet: activity seen with cs held low, got %b want 1", quiet); end
        cs = 1'b1;
        tick(10);
        run_xfer(32'hA5A5A5A5, 32, -1, '0, got, bok, dc, dp);
        n_checks++; if (got[31:0] !== model_stream(32'hA5A5A5A5, 32)) begin n_fail++; $display("FAIL midreset_next_data: got %h want %h", got[31:0], 32'hA5A5A5A5); end
    endtask

    task automatic test_coincident();
        int dc, dp;
        // cs rises together with the last sck rise
        in_buf = 32'h0F0F0F0F;
        cs     = 1'b0;
        tick(HALF);
        for (int i = 0; i < 31; i++) begin
            sck = 1'b1; tick(HALF);
            sck = 1'b0; tick(HALF);
        end
        sck = 1'b1;
        cs  = 1'b1;
        watch_done(12, dc, dp);
        sck = 1'b0;
        tick(6);
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL coincident_done: got %0d want 1", dc); end
        // cs rises one clk before the last sck rise
        cs = 1'b0;
        tick(HALF);
        for (int i = 0; i < 31; i++) begin
            sck = 1'b1; tick(HALF);
            sck = 1'b0; tick(HALF);
        end
        cs = 1'b1;
        tick(1);
        sck = 1'b1;
        watch_done(12, dc, dp);
        sck = 1'b0;
        tick(6);
        n_checks++; if (dc != 0) begin n_fail++; $display("FAIL early_cs_done: got %0d want 0", dc); end
    endtask

    task automatic test_random();
        logic [63:0] got;
        logic [63:0] exp;
        logic [63:0] mask;
        logic [31:0] word;
        bit          bok;
        int          dc, dp, nb;
        for (int r = 0; r < 4; r++) begin
            word = $urandom;
            nb   = $urandom_range(WIDTH, WIDTH + 3);
            exp  = model_stream(word, nb);
            mask = (64'd1 << nb) - 64'd1;
            run_xfer(word, nb, $urandom_range(0, WIDTH - 2), $urandom, got, bok, dc, dp);
            n_checks++; if ((got & mask) !== exp) begin n_fail++; $display("FAIL random_data[%0d]: got %h want %h", r, got & mask, exp); end
            n_checks++; if (dc != 1 || bok !== 1'b1) begin n_fail++; $display("FAIL random_ctrl[%0d]: done %0d busy_ok %b want 1 1", r, dc, bok); end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_stable_data();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_coincident();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
